seg7_bcd_feeder: RTL and testbench

Upstream producer for the 8-digit seven-segment driver. It accepts a 32-bit binary value from the CPU/IO side and converts it to 8 packed BCD digits with a sequential shift-add-3 (double-dabble) engine, one input bit per clock. It then presents the result on o_data with a one-cycle o_cs strobe, which drives the display driver's cs/i_data pair directly. A one-deep pending slot (last-writer-wins) absorbs updates that arrive while a conversion is running.

---
 rtl/seg7_bcd_feeder.sv | 113 +++++++++++
 tb/tb_seg7_bcd_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_bcd_feeder.sv
// Binary-to-packed-BCD feeder for the 8-digit seven-segment driver, using a serial double-dabble engine.
// Build option: define SEG7_FEEDER_SAT_EN to saturate o_data to 99999999 on overflow.
module seg7_bcd_feeder #(
  parameter int IN_W = 32
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [IN_W-1:0] i_bin,
  output logic            o_cs,
  output logic [31:0]     o_data,
  output logic            o_ovf,
  output logic            o_busy,
  output logic            o_drop
);

  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [IN_W-1:0]   sh;
  logic [39:0]       bcd;
  logic [39:0]       bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              pend_vld;
  logic [IN_W-1:0]   pend_data;
  logic              ovf;
  logic [31:0]       result;

  // Add-3 correction is applied to every digit before the shift, all in parallel.
  for (genvar gi = 0; gi < 10; gi++) begin : g_add3
    assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                           : bcd[4*gi +: 4];
  end

  assign ovf = |bcd[39:32];

`ifdef SEG7_FEEDER_SAT_EN
  assign result = ovf ? 32'h9999_9999 : bcd[31:0];
`else
  assign result = bcd[31:0];
`endif

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      bcd       <= '0;
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      o_cs      <= 1'b0;
      o_data    <= '0;
      o_ovf     <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      o_cs   <= 1'b0;
      o_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            sh    <= i_bin;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
          end
        end

        CONV: begin
          {bcd, sh} <= {bcd_adj, sh} << 1;
          cnt       <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(IN_W - 1))
            state <= DONE;
          // Requests during a conversion park in the single pending slot; newest wins.
          if (i_valid) begin
            pend_data <= i_bin;
            pend_vld  <= 1'b1;
            o_drop    <= pend_vld;
          end
        end

        DONE: begin
          o_cs   <= 1'b1;
          o_data <= result;
          o_ovf  <= ovf;
          // A fresh request beats the pending one, which is then discarded.
          if (i_valid) begin
            sh       <= i_bin;
            bcd      <= '0;
            cnt      <= '0;
            state    <= CONV;
            o_drop   <= pend_vld;
            pend_vld <= 1'b0;
          end else if (pend_vld) begin
            sh       <= pend_data;
            bcd      <= '0;
            cnt      <= '0;
            state    <= CONV;
            pend_vld <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_bcd_feeder.sv
// Self-checking bench for seg7_bcd_feeder: arithmetic reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours SEG7_FEEDER_SAT_EN like the design.
module tb_seg7_bcd_feeder;

  localparam int IN_W = 32;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        i_valid = 1'b0;
  logic [31:0] i_bin   = '0;
  logic        o_cs;
  logic [31:0] o_data;
  logic        o_ovf;
  logic        o_busy;
  logic        o_drop;

  int errors = 0;
  int checks = 0;

  seg7_bcd_feeder #(.IN_W(IN_W)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .i_valid(i_valid),
    .i_bin  (i_bin),
    .o_cs   (o_cs),
    .o_data (o_data),
    .o_ovf  (o_ovf),
    .o_busy (o_busy),
    .o_drop (o_drop)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal rendering of a value: {overflow, displayed packed BCD}.
  function automatic logic [32:0] expect_of(input logic [31:0] v);
    logic [31:0] r;
    longint      q;
    logic        ov;
    ov = (v > 32'd99999999);
    q  = {32'b0, v};
    q  = q % 100000000;
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
`ifdef SEG7_FEEDER_SAT_EN
    if (ov) r = 32'h9999_9999;
`endif
    return {ov, r};
  endfunction

  // Reference model: a conversion is a fixed delay of IN_W+1 edges, with a one-deep pending slot.
  logic        m_busy, m_pend_vld, exp_cs, exp_drop, exp_ovf;
  logic [31:0] m_cur, m_pend, exp_data;
  int          m_left;

  always @(posedge clk_in or posedge reset) begin
    logic [32:0] e;
    if (reset) begin
      m_busy = 0; m_pend_vld = 0; m_cur = 0; m_pend = 0; m_left = 0;
      exp_cs = 0; exp_drop = 0; exp_ovf = 0; exp_data = 0;
    end else begin
      exp_cs = 0;
      exp_drop = 0;
      if (!m_busy) begin
        if (i_valid) begin
          m_busy = 1; m_cur = i_bin; m_left = IN_W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          e = expect_of(m_cur);
          exp_cs = 1; exp_data = e[31:0]; exp_ovf = e[32];
          if (i_valid) begin
            exp_drop = m_pend_vld;
            m_pend_vld = 0; m_cur = i_bin; m_left = IN_W + 1;
          end else if (m_pend_vld) begin
            m_pend_vld = 0; m_cur = m_pend; m_left = IN_W + 1;
          end else begin
            m_busy = 0;
          end
        end else if (i_valid) begin
          exp_drop = m_pend_vld;
          m_pend = i_bin; m_pend_vld = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    check("cs",   {31'b0, o_cs},   {31'b0, exp_cs});
    check("drop", {31'b0, o_drop}, {31'b0, exp_drop});
    check("busy", {31'b0, o_busy}, {31'b0, m_busy});
    check("data", o_data, exp_data);
    check("ovf",  {31'b0, o_ovf},  {31'b0, exp_ovf});
    if (o_cs) $display("result data=%h ovf=%b at %0t", o_data, o_ovf, $time);
  end

  task automatic send(input logic [31:0] v);
    i_valid = 1'b1;
    i_bin   = v;
    @(negedge clk_in);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  // Wait for the next strobe; it must arrive exactly 'lat' negedges from now.
  task automatic wait_cs(input string name, input int lat, input logic [31:0] d, input logic ov);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk_in);
      n++;
      if (o_cs) break;
      if (n > 40) begin
        errors++;
        checks++;
        $display("FAIL %s_timeout: no o_cs within %0d cycles, required %0d", name, n, lat);
        return;
      end
    end
    check({name, "_lat"},  n, lat);
    check({name, "_data"}, o_data, d);
    check({name, "_ovf"},  {31'b0, o_ovf}, {31'b0, ov});
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    check("rst_data", o_data, 32'h0);
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    reset = 1'b0;
    idle(2);

    // 1: basic conversion and latency
    send(32'd12345678);
    check("t1_busy_e0", {31'b0, o_busy}, 32'h1);
    wait_cs("t1", 33, 32'h1234_5678, 1'b0);
    check("t1_busy_after", {31'b0, o_busy}, 32'h0);
    idle(3);

    // 2: extremes without overflow
    send(32'd0);
    wait_cs("t2_zero", 33, 32'h0, 1'b0);
    send(32'd99999999);
    wait_cs("t2_max", 33, 32'h9999_9999, 1'b0);
    idle(2);

    // 3: overflow
    send(32'd100000000);
`ifdef SEG7_FEEDER_SAT_EN
    wait_cs("t3_1e8", 33, 32'h9999_9999, 1'b1);
`else
    wait_cs("t3_1e8", 33, 32'h0000_0000, 1'b1);
`endif
    send(32'hFFFF_FFFF);
`ifdef SEG7_FEEDER_SAT_EN
    wait_cs("t3_ffff", 33, 32'h9999_9999, 1'b1);
`else
    wait_cs("t3_ffff", 33, 32'h9496_7295, 1'b1);
`endif
    idle(2);

    // 4: burst, middle value overwritten
    send(32'd10);
    idle(4);
    send(32'd20);
    idle(4);
    send(32'd30);
    check("t4_drop", {31'b0, o_drop}, 32'h1);
    wait_cs("t4_first", 23, 32'h0000_0010, 1'b0);
    wait_cs("t4_second", 33, 32'h0000_0030, 1'b0);
    check("t4_busy_after", {31'b0, o_busy}, 32'h0);
    idle(2);

    // 5: new request on the DONE edge beats the pending value
    send(32'd33);
    idle(4);
    send(32'd44);
    idle(27);
    send(32'd55);
    check("t5_cs", {31'b0, o_cs}, 32'h1);
    check("t5_first", o_data, 32'h0000_0033);
    check("t5_drop", {31'b0, o_drop}, 32'h1);
    wait_cs("t5_next", 33, 32'h0000_0055, 1'b0);
    idle(2);

    // 6: reset aborts a running conversion
    send(32'd12345);
    idle(9);
    #1 reset = 1'b1;
    @(negedge clk_in);
    check("t6_data", o_data, 32'h0);
    check("t6_busy", {31'b0, o_busy}, 32'h0);
    check("t6_cs", {31'b0, o_cs}, 32'h0);
    @(negedge clk_in);
    #1 reset = 1'b0;
    idle(40);
    check("t6_quiet", o_data, 32'h0);
    send(32'd7);
    wait_cs("t6_seven", 33, 32'h0000_0007, 1'b0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
